wc_tile_feeder: RTL and testbench

Upstream stage of the Winograd F(2,3) core `wc`. It takes a serial stream of signed DW-bit samples, one row at a time, and forms overlapping 4-sample input tiles at stride 2. Each tile is presented as the packed 4*DW-bit D bus that `wc` consumes. It handles row start, zero-padding at row end, and valid/ready backpressure.

---
 rtl/wc_pkg.sv | 35 +++
 rtl/wc_tile_feeder_if.sv | 31 +++
 rtl/wc_window_sr.sv | 50 +++++
 rtl/wc_tile_feeder.sv | 150 +++++++++++++++
 tb/tb_wc_tile_feeder.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/wc_pkg.sv
`default_nettype none
// ============================================================================
// Module  : wc_pkg
// Brief   : Shared constants, FSM encoding and tile packing for the wc core.
// Revision: 1.0
// ============================================================================
package wc_pkg;

    localparam int DW          = 10;
    localparam int TILE_N      = 4;
    localparam int TILE_STRIDE = 2;
    localparam int OUT_N       = 2;

    localparam logic [1:0] ST_FILL   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_PAD    = 2'd2;

    typedef enum logic [1:0] {
        FILL   = ST_FILL,
        STREAM = ST_STREAM,
        PAD    = ST_PAD
    } feeder_state_t;

    // Slot 0 is the oldest sample and lands in the most significant field.
    function automatic logic [TILE_N*DW-1:0] pack_tile(input logic [TILE_N-1:0][DW-1:0] win);
        logic [TILE_N*DW-1:0] t;
        t = '0;
        for (int i = 0; i < TILE_N; i++) begin
            t[(TILE_N-i)*DW-1 -: DW] = win[i];
        end
        return t;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wc_tile_feeder_if.sv
`default_nettype none
// ============================================================================
// Module  : wc_tile_feeder_if
// Brief   : Sample-in / tile-out handshake bundle of the tile feeder.
// Revision: 1.0
// ============================================================================
interface wc_tile_feeder_if #(
    parameter int DW  = wc_pkg::DW,
    parameter int TCW = 8
);
    logic [DW-1:0]   s_data;
    logic            s_valid;
    logic            s_last;
    logic            s_ready;
    logic [4*DW-1:0] t_data;
    logic            t_valid;
    logic            t_last;
    logic            t_ready;
    logic [TCW-1:0]  t_idx;

    modport master (
        output s_data, s_valid, s_last, t_ready,
        input  s_ready, t_data, t_valid, t_last, t_idx
    );

    modport slave (
        input  s_data, s_valid, s_last, t_ready,
        output s_ready, t_data, t_valid, t_last, t_idx
    );
endinterface
`default_nettype wire

// File: rtl/wc_window_sr.sv
`default_nettype none
// ============================================================================
// Module  : wc_window_sr
// Brief   : Sliding sample window with shift-in, zero-inject and clear.
// Revision: 1.0
// ============================================================================
module wc_window_sr
    import wc_pkg::*;
#(
    parameter int DW    = wc_pkg::DW,
    parameter int DEPTH = wc_pkg::TILE_N
) (
    input  wire logic                       clk,
    input  wire logic                       rst,
    input  wire logic                       i_shift,
    input  wire logic                       i_zero,
    input  wire logic                       i_clr,
    input  wire logic [DW-1:0]              i_din,
    output      logic [DEPTH-1:0][DW-1:0]   o_win,
    output      logic [DEPTH-1:0][DW-1:0]   o_win_shifted
);

    logic [DEPTH-1:0][DW-1:0] r_win;
    logic [DEPTH-1:0][DW-1:0] w_shifted;

    // Preview of the window after this cycle's shift, so a tile can be
    // captured on the same edge the completing sample arrives.
    always_comb begin
        w_shifted = '0;
        for (int i = 0; i < DEPTH-1; i++) begin
            w_shifted[i] = r_win[i+1];
        end
        w_shifted[DEPTH-1] = i_zero ? '0 : i_din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win <= '0;
        end else if (i_clr) begin
            r_win <= '0;
        end else if (i_shift) begin
            r_win <= w_shifted;
        end
    end

    assign o_win         = r_win;
    assign o_win_shifted = w_shifted;

endmodule
`default_nettype wire

// File: rtl/wc_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module  : wc_tile_feeder
// Brief   : Forms stride-2 overlapping 4-sample tiles from a row sample stream.
// Revision: 1.0
// ============================================================================
module wc_tile_feeder
    import wc_pkg::*;
#(
    parameter int DW  = wc_pkg::DW,
    parameter int TCW = 8
) (
    input  wire logic          clk,
    input  wire logic          rst,
    wc_tile_feeder_if.slave    bus
);

    localparam logic [2:0] C_LAST_SLOT = 3'(TILE_N - 1);
    localparam logic [2:0] C_LAST_PAIR = 3'(TILE_STRIDE - 1);

    feeder_state_t            r_state, w_state_nxt;
    logic [2:0]               r_cnt, w_cnt_nxt;
    logic                     w_out_free, w_accept;
    logic                     w_shift, w_zero, w_clr, w_emit, w_emit_last;
    logic [TILE_N-1:0][DW-1:0] w_win, w_win_shifted;
    logic [4*DW-1:0]          r_tdata;
    logic                     r_tvalid, r_tlast;
    logic [TCW-1:0]           r_tidx;

    assign w_out_free  = !r_tvalid || bus.t_ready;
    assign bus.s_ready = rst && (r_state != PAD) && w_out_free;
    assign w_accept    = bus.s_valid && bus.s_ready;

    wc_window_sr #(.DW(DW), .DEPTH(TILE_N)) u_window (
        .clk           (clk),
        .rst           (rst),
        .i_shift       (w_shift),
        .i_zero        (w_zero),
        .i_clr         (w_clr),
        .i_din         (bus.s_data),
        .o_win         (w_win),
        .o_win_shifted (w_win_shifted)
    );

    // r_cnt: samples held while filling, pending samples while streaming,
    // window fill level while padding.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift     = 1'b0;
        w_zero      = 1'b0;
        w_clr       = 1'b0;
        w_emit      = 1'b0;
        w_emit_last = 1'b0;
        case (r_state)
            FILL: begin
                if (w_accept) begin
                    w_shift = 1'b1;
                    if (r_cnt == C_LAST_SLOT) begin
                        w_emit      = 1'b1;
                        w_emit_last = bus.s_last;
                        w_cnt_nxt   = '0;
                        if (bus.s_last) w_clr       = 1'b1;
                        else            w_state_nxt = STREAM;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                        if (bus.s_last) w_state_nxt = PAD;
                    end
                end
            end
            STREAM: begin
                if (w_accept) begin
                    w_shift = 1'b1;
                    if (r_cnt == C_LAST_PAIR) begin
                        w_emit      = 1'b1;
                        w_emit_last = bus.s_last;
                        w_cnt_nxt   = '0;
                        if (bus.s_last) begin
                            w_clr       = 1'b1;
                            w_state_nxt = FILL;
                        end
                    end else if (bus.s_last) begin
                        w_cnt_nxt   = C_LAST_SLOT;
                        w_state_nxt = PAD;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            PAD: begin
                if (w_out_free) begin
                    w_shift = 1'b1;
                    w_zero  = 1'b1;
                    if (r_cnt == C_LAST_SLOT) begin
                        w_emit      = 1'b1;
                        w_emit_last = 1'b1;
                        w_clr       = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = FILL;
                    end else begin
                        w_cnt_nxt = r_cnt + 3'd1;
                    end
                end
            end
            default: begin
                w_clr       = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = FILL;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A new tile may replace the one being taken on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tdata  <= '0;
            r_tvalid <= 1'b0;
            r_tlast  <= 1'b0;
            r_tidx   <= '0;
        end else begin
            if (r_tvalid && bus.t_ready) begin
                r_tidx <= r_tlast ? '0 : r_tidx + TCW'(1);
            end
            if (w_emit) begin
                r_tdata  <= pack_tile(w_win_shifted);
                r_tvalid <= 1'b1;
                r_tlast  <= w_emit_last;
            end else if (bus.t_ready) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign bus.t_data  = r_tdata;
    assign bus.t_valid = r_tvalid;
    assign bus.t_last  = r_tlast;
    assign bus.t_idx   = r_tidx;

endmodule
`default_nettype wire

// File: tb/tb_wc_tile_feeder.sv
`default_nettype none
// ============================================================================
// Module  : tb_wc_tile_feeder
// Brief   : Directed self-checking bench for the tile feeder.
// Revision: 1.0
// ============================================================================
module tb_wc_tile_feeder;
    import wc_pkg::*;

    localparam int C_DW  = 10;
    localparam int C_TCW = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    wc_tile_feeder_if #(.DW(C_DW), .TCW(C_TCW)) bus ();

    wc_tile_feeder #(.DW(C_DW), .TCW(C_TCW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] tl(input int a, input int b, input int c, input int d);
        logic [C_DW-1:0] x0, x1, x2, x3;
        x0 = a[C_DW-1:0];
        x1 = b[C_DW-1:0];
        x2 = c[C_DW-1:0];
        x3 = d[C_DW-1:0];
        return {24'd0, x0, x1, x2, x3};
    endfunction

    // Called at a falling edge; returns at the falling edge after the accept.
    task automatic send(input int d, input bit last);
        int n;
        n = 0;
        bus.s_data  = d[C_DW-1:0];
        bus.s_valid = 1'b1;
        bus.s_last  = last;
        #1;
        while (!bus.s_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("s_ready_wait", {63'd0, bus.s_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    initial begin
        bus.s_data  = '0;
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        bus.t_ready = 1'b1;

        #1;
        chk("rst_t_valid", {63'd0, bus.t_valid}, 64'd0);
        chk("rst_t_last",  {63'd0, bus.t_last},  64'd0);
        chk("rst_t_idx",   {56'd0, bus.t_idx},   64'd0);
        chk("rst_t_data",  {24'd0, bus.t_data},  64'd0);
        chk("rst_s_ready", {63'd0, bus.s_ready}, 64'd0);
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Row of exactly four samples
        send(2, 0); send(-10, 0); send(3, 0);
        chk("r4_no_early_tile", {63'd0, bus.t_valid}, 64'd0);
        send(4, 1);
        chk("r4_valid", {63'd0, bus.t_valid}, 64'd1);
        chk("r4_data",  {24'd0, bus.t_data}, {24'd0, 40'b0000000010_1111110110_0000000011_0000000100});
        chk("r4_last",  {63'd0, bus.t_last}, 64'd1);
        chk("r4_idx",   {56'd0, bus.t_idx},  64'd0);

        // Row of six samples: two tiles, no padding
        send(2, 0); send(-10, 0); send(3, 0); send(4, 0);
        chk("r6_t0_data", {24'd0, bus.t_data}, tl(2, -10, 3, 4));
        chk("r6_t0_last", {63'd0, bus.t_last}, 64'd0);
        chk("r6_t0_idx",  {56'd0, bus.t_idx},  64'd0);
        send(-19, 0);
        chk("r6_mid_valid", {63'd0, bus.t_valid}, 64'd0);
        send(-6, 1);
        chk("r6_t1_valid", {63'd0, bus.t_valid}, 64'd1);
        chk("r6_t1_data",  {24'd0, bus.t_data}, {24'd0, 40'b0000000011_0000000100_1111101101_1111111010});
        chk("r6_t1_last",  {63'd0, bus.t_last}, 64'd1);
        chk("r6_t1_idx",   {56'd0, bus.t_idx},  64'd1);

        // Row of five samples: one zero of padding
        send(-19, 0); send(-6, 0); send(3, 0); send(-9, 0);
        chk("r5_t0_data", {24'd0, bus.t_data}, tl(-19, -6, 3, -9));
        chk("r5_t0_last", {63'd0, bus.t_last}, 64'd0);
        send(7, 1);
        #1;
        chk("r5_pad_s_ready", {63'd0, bus.s_ready}, 64'd0);
        chk("r5_pad_valid",   {63'd0, bus.t_valid}, 64'd0);
        @(negedge clk);
        chk("r5_t1_valid", {63'd0, bus.t_valid}, 64'd1);
        chk("r5_t1_data",  {24'd0, bus.t_data}, tl(3, -9, 7, 0));
        chk("r5_t1_last",  {63'd0, bus.t_last}, 64'd1);
        chk("r5_t1_idx",   {56'd0, bus.t_idx},  64'd1);
        #1;
        chk("r5_after_pad_s_ready", {63'd0, bus.s_ready}, 64'd1);
        @(negedge clk);

        // Row of one sample: three zeros of padding
        send(5, 1);
        #1;
        chk("r1_pad0_s_ready", {63'd0, bus.s_ready}, 64'd0);
        chk("r1_pad0_valid",   {63'd0, bus.t_valid}, 64'd0);
        @(negedge clk); #1;
        chk("r1_pad1_s_ready", {63'd0, bus.s_ready}, 64'd0);
        chk("r1_pad1_valid",   {63'd0, bus.t_valid}, 64'd0);
        @(negedge clk); #1;
        chk("r1_pad2_s_ready", {63'd0, bus.s_ready}, 64'd0);
        chk("r1_pad2_valid",   {63'd0, bus.t_valid}, 64'd0);
        @(negedge clk);
        chk("r1_valid", {63'd0, bus.t_valid}, 64'd1);
        chk("r1_data",  {24'd0, bus.t_data}, tl(5, 0, 0, 0));
        chk("r1_last",  {63'd0, bus.t_last}, 64'd1);
        chk("r1_idx",   {56'd0, bus.t_idx},  64'd0);
        @(negedge clk);

        // Backpressure: tile held while the next row's first sample waits
        bus.t_ready = 1'b0;
        send(2, 0); send(-10, 0); send(3, 0); send(4, 1);
        bus.s_data  = 10'd11;
        bus.s_valid = 1'b1;
        bus.s_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_data",    {24'd0, bus.t_data}, tl(2, -10, 3, 4));
            chk("bp_valid",   {63'd0, bus.t_valid}, 64'd1);
            chk("bp_s_ready", {63'd0, bus.s_ready}, 64'd0);
            @(negedge clk);
        end
        bus.t_ready = 1'b1;
        #1;
        chk("bp_release_s_ready", {63'd0, bus.s_ready}, 64'd1);
        @(posedge clk);
        @(negedge clk);
        bus.s_valid = 1'b0;
        chk("bp_taken_valid", {63'd0, bus.t_valid}, 64'd0);
        send(12, 0); send(13, 0); send(14, 1);
        chk("bp_next_data", {24'd0, bus.t_data}, tl(11, 12, 13, 14));
        chk("bp_next_last", {63'd0, bus.t_last}, 64'd1);
        chk("bp_next_idx",  {56'd0, bus.t_idx},  64'd0);

        // Reset after three samples of a row
        send(6, 0); send(7, 0); send(8, 0);
        #2;
        rst = 1'b0;
        #1;
        chk("mrst_s_ready", {63'd0, bus.s_ready}, 64'd0);
        chk("mrst_t_valid", {63'd0, bus.t_valid}, 64'd0);
        chk("mrst_t_data",  {24'd0, bus.t_data},  64'd0);
        chk("mrst_t_idx",   {56'd0, bus.t_idx},   64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        send(2, 0);
        chk("mrst_no_stale_tile", {63'd0, bus.t_valid}, 64'd0);
        send(-10, 0); send(3, 0);
        chk("mrst_no_early_tile", {63'd0, bus.t_valid}, 64'd0);
        send(4, 1);
        chk("mrst_valid", {63'd0, bus.t_valid}, 64'd1);
        chk("mrst_data",  {24'd0, bus.t_data}, {24'd0, 40'b0000000010_1111110110_0000000011_0000000100});
        chk("mrst_last",  {63'd0, bus.t_last}, 64'd1);
        chk("mrst_idx",   {56'd0, bus.t_idx},  64'd0);
        @(negedge clk);
        chk("mrst_taken", {63'd0, bus.t_valid}, 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
